// File: rtl/puf_soc_cnt_pkg.sv
// Shared types and constants for the puf_soc windowed event counter.
// The PUF_SOC_CNT_WRAP_EN build option is consumed in puf_soc_cnt_lane.
package puf_soc_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_CNT_BIT_SIZE = 5;
  localparam int DEF_WIN_W        = 8;

  function automatic int unsigned lane_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/puf_soc_cnt_lane.sv
// One event-count lane: saturating by default, modulo-wrapping with a sticky
// overflow flag when PUF_SOC_CNT_WRAP_EN is defined.
module puf_soc_cnt_lane
  import puf_soc_cnt_pkg::*;
#(
  parameter int CNT_BIT_SIZE = DEF_CNT_BIT_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    evt,
  output logic [CNT_BIT_SIZE-1:0] cnt,
  output logic                    full
);

  localparam logic [CNT_BIT_SIZE-1:0] CNT_MAX = CNT_BIT_SIZE'(lane_max(CNT_BIT_SIZE));
  localparam logic [CNT_BIT_SIZE-1:0] CNT_ONE = CNT_BIT_SIZE'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (enable && evt) begin
`ifdef PUF_SOC_CNT_WRAP_EN
      cnt <= cnt + CNT_ONE;
      if (cnt == CNT_MAX) full <= 1'b1;
`else
      // flag rises on the same edge the lane lands on its maximum
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
        if (cnt == CNT_MAX - CNT_ONE) full <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/puf_soc_win_counter.sv
// Multi-lane gated event counter with a programmable window and a valid/ready result.
// Lane behaviour (saturate vs. wrap) is selected by PUF_SOC_CNT_WRAP_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for i_start; last result still visible on o_cnt
// ST_COUNT | window open, lanes count i_evt, window counter runs down
// ST_HOLD  | result valid and frozen until i_ready
module puf_soc_win_counter
  import puf_soc_cnt_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CNT_BIT_SIZE = DEF_CNT_BIT_SIZE,
  parameter int WIN_W        = DEF_WIN_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic [WIN_W-1:0]               i_win_len,
  input  logic [NUM_CH-1:0]              i_evt,
  input  logic                           i_ready,
  output logic                           o_busy,
  output logic                           o_valid,
  output logic [NUM_CH*CNT_BIT_SIZE-1:0] o_cnt,
  output logic [NUM_CH-1:0]              o_cnt_full
);

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t                          state;
  logic   [WIN_W-1:0]              win_cnt;
  logic                            clear;
  logic                            enable;
  logic   [NUM_CH*CNT_BIT_SIZE-1:0] cnt;
  logic   [NUM_CH-1:0]             full;

  assign clear  = (state == ST_IDLE) && i_start;
  assign enable = (state == ST_COUNT);

  // a zero length still opens a one-cycle window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      win_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            win_cnt <= (i_win_len == '0) ? WIN_ONE : i_win_len;
            state   <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          win_cnt <= win_cnt - WIN_ONE;
          if (win_cnt == WIN_ONE) state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (i_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    puf_soc_cnt_lane #(
      .CNT_BIT_SIZE(CNT_BIT_SIZE)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .enable(enable),
      .evt   (i_evt[k]),
      .cnt   (cnt[k*CNT_BIT_SIZE +: CNT_BIT_SIZE]),
      .full  (full[k])
    );
  end

  assign o_cnt      = cnt;
  assign o_cnt_full = full;
  assign o_busy     = (state != ST_IDLE);
  assign o_valid    = (state == ST_HOLD);

endmodule

// File: tb/tb_puf_soc_win_counter.sv
// Randomised self-checking bench for puf_soc_win_counter against a per-window
// event-tally model; honours PUF_SOC_CNT_WRAP_EN the same way as the RTL build.
module tb_puf_soc_win_counter;

  localparam int NUM_CH = 4;
  localparam int CB     = 5;
  localparam int WW     = 8;
  localparam int LMAX   = (1 << CB) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_start = 1'b0;
  logic [WW-1:0]        i_win_len = '0;
  logic [NUM_CH-1:0]    i_evt = '0;
  logic                 i_ready = 1'b0;
  logic                 o_busy;
  logic                 o_valid;
  logic [NUM_CH*CB-1:0] o_cnt;
  logic [NUM_CH-1:0]    o_cnt_full;

  int checks = 0;
  int failures = 0;

  int                mcnt [NUM_CH];
  logic [NUM_CH-1:0] mfull;

  puf_soc_win_counter #(
    .NUM_CH(NUM_CH),
    .CNT_BIT_SIZE(CB),
    .WIN_W(WW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_win_len (i_win_len),
    .i_evt     (i_evt),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_valid   (o_valid),
    .o_cnt     (o_cnt),
    .o_cnt_full(o_cnt_full)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_packed();
    logic [31:0] p = '0;
    for (int k = 0; k < NUM_CH; k++) p = p | (32'(mcnt[k]) << (k * CB));
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tally one cycle of events into the expected result.
  task automatic model_evt(input logic [NUM_CH-1:0] e);
    for (int k = 0; k < NUM_CH; k++) begin
      if (e[k]) begin
`ifdef PUF_SOC_CNT_WRAP_EN
        if (mcnt[k] == LMAX) begin
          mcnt[k]  = 0;
          mfull[k] = 1'b1;
        end else begin
          mcnt[k] = mcnt[k] + 1;
        end
`else
        if (mcnt[k] < LMAX) mcnt[k] = mcnt[k] + 1;
        if (mcnt[k] == LMAX) mfull[k] = 1'b1;
`endif
      end
    end
  endtask

  // mode: 0 random, 1 basic pattern, 2 lane0 held high, 3 all lanes high
  task automatic measure(input string tag, input int len, input int mode);
    int eff;
    logic [NUM_CH-1:0] e;
    logic [31:0] held_cnt;
    logic [31:0] held_full;
    eff = (len == 0) ? 1 : len;
    i_win_len = WW'(len);
    i_start   = 1'b1;
    i_ready   = 1'($urandom);
    i_evt     = NUM_CH'($urandom);
    step();
    check_val({tag, "_busy_start"}, 32'(o_busy), 32'd1);
    i_start = 1'b0;
    for (int k = 0; k < NUM_CH; k++) mcnt[k] = 0;
    mfull = '0;
    for (int c = 0; c < eff; c++) begin
      case (mode)
        1:       e = {1'b1, 1'b0, (c % 2 == 0), 1'b1};
        2:       e = NUM_CH'($urandom) | NUM_CH'(1);
        3:       e = '1;
        default: e = NUM_CH'($urandom);
      endcase
      i_evt   = e;
      i_start = 1'($urandom);
      i_ready = 1'($urandom);
      model_evt(e);
      step();
      check_val({tag, "_valid_timing"}, 32'(o_valid), (c == eff - 1) ? 32'd1 : 32'd0);
    end
    i_start = 1'b0;
    check_val({tag, "_busy_hold"}, 32'(o_busy), 32'd1);
    check_val({tag, "_cnt"}, 32'(o_cnt), model_packed());
    check_val({tag, "_full"}, 32'(o_cnt_full), 32'(mfull));
    held_cnt  = model_packed();
    held_full = 32'(mfull);
    for (int b = 0; b < int'($urandom_range(1, 5)); b++) begin
      i_ready = 1'b0;
      i_start = 1'($urandom);
      i_evt   = NUM_CH'($urandom);
      step();
      check_val({tag, "_bp_valid"}, 32'(o_valid), 32'd1);
      check_val({tag, "_bp_cnt"}, 32'(o_cnt), held_cnt);
      check_val({tag, "_bp_full"}, 32'(o_cnt_full), held_full);
    end
    i_ready = 1'b1;
    i_start = 1'b1;
    step();
    check_val({tag, "_accept_valid"}, 32'(o_valid), 32'd0);
    check_val({tag, "_accept_busy"}, 32'(o_busy), 32'd0);
    i_ready = 1'b0;
    i_start = 1'b0;
    i_evt   = NUM_CH'($urandom);
    step();
    check_val({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    check_val({tag, "_idle_cnt"}, 32'(o_cnt), held_cnt);
    check_val({tag, "_idle_full"}, 32'(o_cnt_full), held_full);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_cnt"}, 32'(o_cnt), 32'd0);
    check_val({tag, "_full"}, 32'(o_cnt_full), 32'd0);
    check_val({tag, "_valid"}, 32'(o_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    repeat (5) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    measure("basic", 10, 1);
    check_val("basic_const", 32'(o_cnt), {12'd0, 5'd10, 5'd0, 5'd5, 5'd10});
    check_val("basic_const_full", 32'(o_cnt_full), 32'd0);

    measure("sat", 40, 2);
`ifdef PUF_SOC_CNT_WRAP_EN
    check_val("sat_lane0", 32'(o_cnt[CB-1:0]), 32'd8);
`else
    check_val("sat_lane0", 32'(o_cnt[CB-1:0]), 32'd31);
`endif
    check_val("sat_full0", 32'(o_cnt_full[0]), 32'd1);

    measure("zero_len", 0, 3);
    check_val("zero_len_const", 32'(o_cnt), {12'd0, 5'd1, 5'd1, 5'd1, 5'd1});

    measure("len31_all", 31, 3);
    measure("len32_all", 32, 3);

    for (int r = 0; r < 6; r++) measure("rand", int'($urandom_range(0, 45)), 0);

    // abort a window with an asynchronous reset between clock edges
    i_win_len = WW'(20);
    i_start   = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 7; c++) begin
      i_evt = NUM_CH'($urandom) | NUM_CH'(1);
      step();
    end
    check_val("mid_busy", 32'(o_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_all_zero("post_rst");

    measure("after_rst", 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/puf_soc_win_counter.md
Name: puf_soc_win_counter

Overview:
- Multi-channel, gated event counter for PUF response evaluation.
- Each of NUM_CH lanes counts single-cycle event pulses during a programmable measurement window, e.g. synchronised ring-oscillator edge pulses.
- Results are presented on a valid/ready handshake.
- Successor to the single-channel free-running counter: adds channels, a window length, saturation/overflow flags and back-pressure.

Parameters:
- NUM_CH, 4, number of independent count lanes.
- CNT_BIT_SIZE, 5, width of each lane count.
- WIN_W, 8, width of the window-length input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start a measurement; sampled only in IDLE.
- i_win_len  in  WIN_W  window length in cycles; sampled with i_start.
- i_evt  in  NUM_CH  per-lane event pulse; already synchronous to clk.
- i_ready  in  1  consumer accepts the result.
- o_busy  out  1  high in COUNT and HOLD.
- o_valid  out  1  result available (HOLD state).
- o_cnt  out  NUM_CH*CNT_BIT_SIZE  packed lane counts; lane k occupies bits [k*CNT_BIT_SIZE +: CNT_BIT_SIZE].
- o_cnt_full  out  NUM_CH  per-lane limit flag.

Behaviour:
- Reset is asynchronous and active-low on every flop. All outputs reset to 0, the FSM resets to IDLE and the window counter resets to 0. Reset applied mid-window aborts the window immediately.
- FSM states:
  - IDLE:
    - i_start=1 -> COUNT.
    - On that edge: all lane counts and o_cnt_full clear; window counter loads max(i_win_len,1). A length of 0 is treated as 1.
  - COUNT:
    - Each cycle, lane k increments when i_evt[k]=1.
    - The window counter decrements every cycle. On the edge where it reaches 0 (the len-th edge after the start edge), the FSM moves to HOLD.
    - Events present in exactly len cycles are counted; the event on the final edge is included.
  - HOLD:
    - o_valid=1; o_cnt and o_cnt_full are frozen.
    - i_ready=1 -> IDLE on the next edge; o_valid drops.
    - i_ready=0 -> stay in HOLD; outputs must remain stable.
- o_valid rises exactly len edges after the edge that samples i_start.
- i_start is ignored in COUNT and HOLD. There is no queueing. i_start together with i_ready in HOLD does not restart the measurement.
- In IDLE, o_cnt keeps the last result until the next start.
- Saturation (default): a lane at 2^CNT_BIT_SIZE-1 stays there. o_cnt_full[k] sets when the lane reaches the maximum and stays set (sticky) until the next start.
- Lanes are fully independent. Simultaneous events on all lanes in the same cycle must all be counted.
- o_busy = (state != IDLE), decoded from registered state.

Optional Feature:
- Macro: PUF_SOC_CNT_WRAP_EN.
- Defined: lanes wrap modulo 2^CNT_BIT_SIZE instead of saturating. o_cnt_full[k] becomes a sticky overflow flag, set on the wrap from max to 0.
- Undefined: saturating behaviour as described under Behaviour.

Decomposition:
- Package puf_soc_cnt_pkg holds:
  - the FSM state enum (IDLE, COUNT, HOLD), 2 bits;
  - default parameter constants;
  - a function returning the lane maximum for a given width.
- Sub-module puf_soc_cnt_lane: one per channel, instantiated in a generate loop.
  - Inputs: clk, rst_n, clear, enable, evt.
  - Outputs: cnt, full.
  - Contains the saturate/wrap logic and the macro-dependent code.
- The top level holds the FSM, the window counter, the handshake and output packing.

Test Plan (NUM_CH=4, CNT_BIT_SIZE=5, WIN_W=8):
1. Reset: hold rst_n=0 for 5 cycles, then release -> o_cnt=0, o_cnt_full=0, o_valid=0, o_busy=0. Assert rst_n=0 asynchronously between edges -> all outputs clear before the next edge.
2. Basic window: i_win_len=10; lane0 constant 1, lane1 alternating, lane2 0, lane3 1 -> o_valid on the 10th edge after start; counts {10,5,0,10}; full=0.
3. Saturation: i_win_len=40, lane0=1 -> o_cnt lane0=31, o_cnt_full=4'b0001.
   - With PUF_SOC_CNT_WRAP_EN defined -> lane0=8, full[0]=1.
4. Back-pressure: after o_valid rises, keep i_ready=0 for 5 cycles while pulsing i_start and toggling i_evt -> o_valid, o_cnt and o_cnt_full stay unchanged. Then i_ready=1 -> IDLE next edge.
5. Zero length: i_win_len=0, i_evt=4'b1111 -> window of 1 cycle; counts {1,1,1,1}.
6. Reset mid-COUNT: i_win_len=20, assert rst_n=0 at cycle 7 -> immediate IDLE, counts 0. A new start with i_win_len=3 then completes normally with counts ≤3.
